ftoi_pipe: RTL and testbench

FTOI_PIPE -- requirements
Module: ftoi_pipe

---
 rtl/ftoi_pipe.sv | 115 +++++++++++
 tb/tb_ftoi_pipe.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ftoi_pipe.sv
// Two-stage binary32 to signed int32 converter: S1 unpacks and aligns the operand, S2 rounds
// half away from zero, negates and saturates. Both stages use a valid/ready handshake.
module ftoi_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  // Returns {magnitude, half}. Only meaningful for 126 <= e <= 157.
  // The significand is placed so that the binary point sits at bit 32.
  function automatic logic [32:0] align(input logic [7:0] e, input logic [22:0] f);
    logic [63:0] ext;
    logic [63:0] sh;
    ext = {8'd0, 1'b1, f, 32'd0};
    if (e >= 8'd150) sh = ext << (e - 8'd150);
    else             sh = ext >> (8'd150 - e);
    return {sh[63:32], sh[31]};
  endfunction

  function automatic logic [31:0] round_mag(input logic [31:0] mag, input logic half);
    return mag + {31'd0, half};
  endfunction

  function automatic logic [31:0] sat_val(input logic neg);
    return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

  logic        vld_p1_q, vld_p2_q;
  logic        sign_p1_d, sign_p1_q;
  logic [31:0] mag_p1_d, mag_p1_q;
  logic        half_p1_d, half_p1_q;
  logic        sat_p1_d, sat_p1_q;
  logic        ovf_p1_d, ovf_p1_q;

  logic signed [31:0] rnd_p2;
  logic signed [31:0] y_p2_d, y_p2_q;
  logic               ovf_p2_d, ovf_p2_q;

  logic adv_p2;
  logic [7:0]  exp_x;
  logic [22:0] frac_x;

  assign exp_x  = x[30:23];
  assign frac_x = x[22:0];

  assign adv_p2   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv_p2;

  // Stage 1: classify and align
  always_comb begin
    sign_p1_d = x[31];
    mag_p1_d  = 32'd0;
    half_p1_d = 1'b0;
    sat_p1_d  = 1'b0;
    ovf_p1_d  = 1'b0;
    if (exp_x == 8'hFF && frac_x != 23'd0) begin
      // NaN saturates positive regardless of its sign bit.
      sign_p1_d = 1'b0;
      sat_p1_d  = 1'b1;
      ovf_p1_d  = 1'b1;
    end else if (exp_x >= 8'd158) begin
      // -2^31 is the one value in this range that is representable.
      sat_p1_d = 1'b1;
      ovf_p1_d = (x != 32'hCF00_0000);
    end else if (exp_x >= 8'd126) begin
      {mag_p1_d, half_p1_d} = align(exp_x, frac_x);
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      sign_p1_q <= sign_p1_d;
      mag_p1_q  <= mag_p1_d;
      half_p1_q <= half_p1_d;
      sat_p1_q  <= sat_p1_d;
      ovf_p1_q  <= ovf_p1_d;
    end
  end

  // Stage 2: round, negate, saturate
  always_comb begin
    rnd_p2   = round_mag(mag_p1_q, half_p1_q);
    y_p2_d   = sign_p1_q ? -rnd_p2 : rnd_p2;
    ovf_p2_d = ovf_p1_q;
    if (sat_p1_q) y_p2_d = sat_val(sign_p1_q);
  end

  always_ff @(posedge clk) begin
    if (adv_p2 && vld_p1_q) begin
      y_p2_q   <= y_p2_d;
      ovf_p2_q <= ovf_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      if (in_ready) vld_p1_q <= in_valid;
      if (adv_p2)   vld_p2_q <= vld_p1_q;
    end
  end

  assign out_valid = vld_p2_q;
  assign y         = y_p2_q;
  assign ovf       = ovf_p2_q;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe: a scoreboard records an expected result per accepted operand
// and the output monitor checks order, value, ovf and (when enabled) latency.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rstn, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [31:0] x, y;

  always #5 clk = ~clk;

  ftoi_pipe dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  typedef struct {logic [31:0] y; logic o; int cyc;} exp_t;
  typedef struct {logic [31:0] x; logic [31:0] y; logic o;} vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[24];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc = 0;
  bit   lat_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", {31'd0, out_valid}, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("y", y, mon_e.y);
        chk("ovf", {31'd0, ovf}, {31'd0, mon_e.o});
        if (lat_chk) chk("latency", cyc - mon_e.cyc, 32'd2);
      end
    end
  end

  task automatic send(input logic [31:0] v, input logic [31:0] ey, input logic eo);
    int n;
    n = 0;
    in_valid = 1'b1;
    x = v;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    else sb.push_back('{y: ey, o: eo, cyc: cyc});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(posedge clk);
    end
    #1;
    chk("drain", sb.size(), 32'd0);
  endtask

  // Reference integer-to-float (round to nearest even) plus the integer the float represents.
  function automatic void itof(input logic signed [31:0] i, output logic [31:0] f,
                               output logic [31:0] ey, output logic eo);
    longint li, am, keep, rem, hv, mant, ev;
    int p, sh;
    logic s;
    logic [7:0] e;
    li = longint'(i);
    s = i[31];
    am = s ? -li : li;
    f = 32'd0; ey = 32'd0; eo = 1'b0;
    if (am == 0) return;
    p = 0;
    for (int b = 0; b < 33; b++) if (am[b]) p = b;
    sh = 0;
    keep = am;
    if (p > 23) begin
      sh = p - 23;
      keep = am >> sh;
      rem = am & ((64'sd1 <<< sh) - 1);
      hv = 64'sd1 <<< (sh - 1);
      if (rem > hv || (rem == hv && keep[0])) keep = keep + 1;
      if (keep == (64'sd1 <<< 24)) begin
        keep = keep >> 1;
        p++;
        sh++;
      end
      mant = keep;
    end else begin
      mant = keep << (23 - p);
    end
    e = 8'(127 + p);
    f = {s, e, mant[22:0]};
    ev = keep << sh;
    if (s) ev = -ev;
    if (ev > 64'sd2147483647) begin
      ey = 32'h7FFF_FFFF;
      eo = 1'b1;
    end else begin
      ey = ev[31:0];
    end
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rf, rey;
    logic        reo;
    logic signed [31:0] ri;
    logic signed [31:0] rt_ints[13];

    vecs = '{
      '{32'h3FC00000, 32'h00000002, 1'b0}, '{32'hBFC00000, 32'hFFFFFFFE, 1'b0},
      '{32'h40200000, 32'h00000003, 1'b0}, '{32'h3EFFFFFF, 32'h00000000, 1'b0},
      '{32'h4F000000, 32'h7FFFFFFF, 1'b1}, '{32'hCF000000, 32'h80000000, 1'b0},
      '{32'hFF800000, 32'h80000000, 1'b1}, '{32'hFFC00000, 32'h7FFFFFFF, 1'b1},
      '{32'h00000000, 32'h00000000, 1'b0}, '{32'h80000000, 32'h00000000, 1'b0},
      '{32'h3F000000, 32'h00000001, 1'b0}, '{32'hBF000000, 32'hFFFFFFFF, 1'b0},
      '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0}, '{32'h7F800000, 32'h7FFFFFFF, 1'b1},
      '{32'h7FC00000, 32'h7FFFFFFF, 1'b1}, '{32'h3F7FFFFF, 32'h00000001, 1'b0},
      '{32'h4B000001, 32'h00800001, 1'b0}, '{32'h4B7FFFFF, 32'h00FFFFFF, 1'b0},
      '{32'hC0200000, 32'hFFFFFFFD, 1'b0}, '{32'hCF000001, 32'h80000000, 1'b1},
      '{32'h00000001, 32'h00000000, 1'b0}, '{32'h3FA00000, 32'h00000001, 1'b0},
      '{32'hBEFFFFFF, 32'h00000000, 1'b0}, '{32'hC2F70000, 32'hFFFFFF84, 1'b0}
    };
    rt_ints = '{
      32'sd0, 32'sd1, -32'sd1, 32'sd16777215, -32'sd16777215, 32'sd16777216, 32'sd16777217,
      32'sd16777219, -32'sd16777219, 32'sd2147483647, 32'h80000000, 32'sh7FFFFF80, 32'sh7FFFFFBF
    };

    rstn = 1'b0; in_valid = 1'b0; x = 32'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Full-rate stream with latency checking.
    out_ready = 1'b1;
    lat_chk = 1'b1;
    for (int k = 0; k < 24; k++) send(vecs[k].x, vecs[k].y, vecs[k].o);
    drain();
    lat_chk = 1'b0;

    // Back-pressure: two operands fill the pipe, the third waits.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(vecs[0].x, vecs[0].y, vecs[0].o);
    send(vecs[1].x, vecs[1].y, vecs[1].o);
    in_valid = 1'b1;
    x = vecs[2].x;
    repeat (3) @(negedge clk);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_y_hold", y, vecs[0].y);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(vecs[2].x, vecs[2].y, vecs[2].o);
    send(vecs[3].x, vecs[3].y, vecs[3].o);
    drain();

    // Reset with both stages holding operands.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(vecs[4].x, vecs[4].y, vecs[4].o);
    send(vecs[5].x, vecs[5].y, vecs[5].o);
    @(negedge clk);
    chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_stale", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Round trip through the reference integer-to-float conversion.
    for (int k = 0; k < 13; k++) begin
      itof(rt_ints[k], rf, rey, reo);
      send(rf, rey, reo);
    end
    for (int k = 0; k < 16; k++) begin
      ri = $urandom;
      if (k[0]) ri = ri >>> $urandom_range(0, 31);
      itof(ri, rf, rey, reo);
      send(rf, rey, reo);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
